wb_master: RTL
==============

WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst length field width (beats-1).
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles stb_o waits for ack_i per beat; legal range 2..65535.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  command accept.
REQ-008 cmd_we  in  1  1=write burst, 0=read burst; cmd_adr  in  ADDR_WIDTH  start word address; cmd_len  in  LEN_WIDTH  beats minus 1.
REQ-009 wr_dat  in  DATA_WIDTH, wr_valid  in  1, wr_ready  out  1  write-data stream, one word per beat.
REQ-010 rd_dat  out  DATA_WIDTH, rd_valid  out  1  read-data stream, no backpressure.
REQ-011 done  out  1  command-complete pulse; err  out  1  timeout flag, valid with done.
REQ-012 cyc_o, stb_o, we_o  out  1; adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH; dat_i  in  DATA_WIDTH; ack_i  in  1  Wishbone classic master port.

Function
REQ-013 SHALL implement states IDLE, WDATA, REQ, GAP; all outputs registered except cmd_ready=(state==IDLE) and wr_ready=(state==WDATA).
REQ-014 Command accepted on edge with cmd_valid&cmd_ready: latch we/adr/len, beat counter=0, cyc_o=1, we_o=cmd_we, adr_o=cmd_adr; next state WDATA if write, REQ (stb_o=1) if read.
REQ-015 WDATA: cyc_o=1, stb_o=0; on edge with wr_valid high, dat_o<=wr_dat, stb_o<=1, go REQ; wr_valid low holds WDATA indefinitely (no timeout).
REQ-016 REQ: cyc_o=stb_o=1, adr_o/we_o/dat_o stable; timeout counter cleared on entry, increments each cycle.
REQ-017 REQ with ack_i=1: stb_o<=0; if read, rd_dat<=dat_i and rd_valid<=1 for exactly one cycle.
REQ-018 After ack on non-final beat: adr_o<=adr_o+1 (mod 2^ADDR_WIDTH), beat counter+1, next state WDATA (write) or GAP (read); stb_o low at least one cycle between beats.
REQ-019 GAP: cyc_o=1, stb_o=0 for exactly one cycle, then stb_o<=1, go REQ.
REQ-020 After ack on final beat (counter==len): cyc_o<=0, stb_o<=0, done<=1 one cycle, err<=0, go IDLE; cmd_ready high in the done cycle.
REQ-021 REQ with ack_i=0 in its TIMEOUT-th cycle: cyc_o<=0, stb_o<=0, done<=1, err<=1 one cycle, go IDLE; remaining beats abandoned, no rd_valid for aborted beat.
REQ-022 ack_i SHALL be ignored outside REQ; cmd_valid ignored outside IDLE.
REQ-023 Burst of len+1 beats: read takes 2*(len+1) cycles minimum with zero-wait slave acking one cycle after stb_o; done one cycle after final ack sample.
REQ-024 err SHALL be 0 whenever done is 0.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE and cyc_o, stb_o, we_o, rd_valid, done, err=0, adr_o, dat_o, rd_dat=0, counters=0, regardless of state.
REQ-026 Reset mid-burst SHALL drop cyc_o/stb_o on that edge, no done pulse; first command after rst=1 starts clean.

Verification (bench pairs block with 16-word Wishbone slave model acking one cycle after stb, ack low one cycle after)
REQ-027 Write len=3 adr=3 data 0xA,0xB,0xC,0xD, then read len=3 adr=3 -> rd_valid 4 pulses with 0xA..0xD, adr_o 3,4,5,6, done once each, err=0.
REQ-028 Single read len=0 adr=7 after writing 0x1234 -> exactly one rd_valid with 0x1234, cyc_o high 2 cycles, done next cycle.
REQ-029 TIMEOUT=8, ack_i tied 0, read adr=0 -> stb_o high exactly 8 cycles, then cyc_o=0, done=1, err=1 same cycle, no rd_valid.
REQ-030 Write len=1 with wr_valid held low 5 cycles before each beat -> stb_o stays 0 in WDATA, cyc_o stays 1, both words land correctly, no timeout.
REQ-031 ADDR_WIDTH=4, write len=1 adr=15 -> second beat adr_o=0.
REQ-032 rst=0 during beat 2 of 4-beat read -> cyc_o/stb_o/rd_valid 0 next edge, no done; subsequent read len=0 completes with err=0.

Source files
------------

// File: rtl/wb_master.sv
// Wishbone classic burst master: accepts a read/write burst command and runs one
// stb_o/ack_i handshake per beat, with a per-beat ack timeout that aborts the burst.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, bus released
// WDATA | write burst, bus held (cyc_o=1, stb_o=0) until the next write word arrives
// REQ   | strobe asserted, waiting for ack_i or timeout
// GAP   | read burst, single idle-strobe cycle between beats
module wb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int               TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 last_beat;

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WDATA);
    assign last_beat = (beat_cnt == len_r);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            len_r    <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
            rd_dat   <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        we_o     <= cmd_we;
                        adr_o    <= cmd_adr;
                        len_r    <= cmd_len;
                        beat_cnt <= '0;
                        tmo_cnt  <= '0;
                        cyc_o    <= 1'b1;
                        if (cmd_we) begin
                            state <= WDATA;
                        end else begin
                            stb_o <= 1'b1;
                            state <= REQ;
                        end
                    end
                end
                WDATA: begin
                    if (wr_valid) begin
                        dat_o   <= wr_dat;
                        stb_o   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        stb_o <= 1'b0;
                        if (!we_o) begin
                            rd_dat   <= dat_i;
                            rd_valid <= 1'b1;
                        end
                        if (last_beat) begin
                            cyc_o <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            adr_o    <= adr_o + ADDR_WIDTH'(1);
                            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                            state    <= we_o ? WDATA : GAP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abandon the rest of the burst; the aborted beat returns no data.
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                GAP: begin
                    stb_o   <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= REQ;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
